// File: rtl/hybrid_rng_gen.sv
// hybrid_rng_gen: hybrid random number generator.
// A Galois LFSR and a rule 90/150 cellular-automaton shift register
// (CASR) both advance every non-reset, non-load cycle. After a warm-up
// period the mode-selected combination of their low bits is offered on
// a valid/ready output port. Both registers escape the all-zero lock by
// reloading their init values.
module hybrid_rng_gen #(
    parameter int                 LFSR_W     = 43,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS  = 43'h200_0010_0002,
    parameter logic [LFSR_W-1:0]  LFSR_INIT  = 43'h1FFEC560B4,
    parameter int                 CASR_W     = 37,
    parameter logic [CASR_W-1:0]  CA150_MASK = 37'h0_1000_0000,
    parameter logic [CASR_W-1:0]  CASR_INIT  = 37'hA5728ECEB,
    parameter int                 OUT_W      = 32,
    parameter int                 WARMUP     = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [OUT_W-1:0] seed,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] random_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WARMUP + 1);

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic [LFSR_W-1:0] lfsr_r;
    logic [CASR_W-1:0] casr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [0:0]        state_r;
    logic              out_valid_r;
    logic [OUT_W-1:0]  random_out_r;

    logic [LFSR_W-1:0] lfsr_next_s;
    logic [CASR_W-1:0] casr_next_s;
    logic [OUT_W-1:0]  sample_s;

    // One Galois step; an all-zero register restarts from LFSR_INIT.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        nxt    = '0;
        nxt[0] = cur[LFSR_W-1];
        for (int i = 1; i < LFSR_W; i++) begin
            nxt[i] = cur[i-1] ^ (LFSR_TAPS[i] & cur[LFSR_W-1]);
        end
        if (cur == '0) begin
            nxt = LFSR_INIT;
        end
        return nxt;
    endfunction

    // One cyclic rule 90/150 step; an all-zero register restarts from CASR_INIT.
    function automatic logic [CASR_W-1:0] casr_step(input logic [CASR_W-1:0] cur);
        logic [CASR_W-1:0] nxt;
        nxt = '0;
        for (int i = 0; i < CASR_W; i++) begin
            nxt[i] = cur[(i + CASR_W - 1) % CASR_W] ^ cur[(i + 1) % CASR_W]
                   ^ (CA150_MASK[i] & cur[i]);
        end
        if (cur == '0) begin
            nxt = CASR_INIT;
        end
        return nxt;
    endfunction

    // Next generator values and the mode-selected candidate sample.
    always_comb begin
        lfsr_next_s = lfsr_step(lfsr_r);
        casr_next_s = casr_step(casr_r);
        case (mode)
            2'b01:   sample_s = lfsr_r[OUT_W-1:0];
            2'b10:   sample_s = casr_r[OUT_W-1:0];
            default: sample_s = lfsr_r[OUT_W-1:0] ^ casr_r[OUT_W-1:0];
        endcase
    end

    // Generator state, warm-up sequencing and output handshake register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r       <= LFSR_INIT;
            casr_r       <= CASR_INIT;
            cnt_r        <= '0;
            state_r      <= ST_WARMUP;
            out_valid_r  <= 1'b0;
            random_out_r <= '0;
        end else if (load) begin
            lfsr_r      <= LFSR_W'(seed);
            casr_r      <= CASR_W'(seed);
            cnt_r       <= '0;
            state_r     <= ST_WARMUP;
            out_valid_r <= 1'b0;
        end else begin
            lfsr_r <= lfsr_next_s;
            casr_r <= casr_next_s;
            case (state_r)
                ST_WARMUP: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WARMUP - 1)) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Capture the pre-step registers when the slot is free.
                    if (!out_valid_r || out_ready) begin
                        random_out_r <= sample_s;
                        out_valid_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_WARMUP;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_r;
    assign random_out = random_out_r;
    assign busy       = (state_r == ST_WARMUP);

endmodule

// File: tb/tb_hybrid_rng_gen.sv
// Self-checking bench for hybrid_rng_gen: two instances (WARMUP=4 and
// WARMUP=1) share the same stimulus and are compared every cycle against
// a step-count based reference model, plus directed constant checks.
module tb_hybrid_rng_gen;

    localparam logic [42:0] L_TAPS = 43'h200_0010_0002;
    localparam logic [42:0] L_INIT = 43'h1FFEC560B4;
    localparam logic [36:0] C_MASK = 37'h0_1000_0000;
    localparam logic [36:0] C_INIT = 37'hA5728ECEB;

    logic        clk = 1'b0;
    logic        reset, load, out_ready;
    logic [31:0] seed;
    logic [1:0]  mode;
    logic        a_valid, b_valid, a_busy, b_busy;
    logic [31:0] a_out, b_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = WARMUP 4, index 1 = WARMUP 1.
    logic [42:0] m_l [2];
    logic [36:0] m_c [2];
    int          m_n [2];
    logic        m_v [2];
    logic [31:0] m_o [2];
    int          wu  [2] = '{4, 1};

    always #5 clk = ~clk;

    hybrid_rng_gen #(.WARMUP(4)) dut_a (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .mode(mode),
        .out_ready(out_ready), .out_valid(a_valid), .random_out(a_out), .busy(a_busy)
    );

    hybrid_rng_gen #(.WARMUP(1)) dut_b (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .mode(mode),
        .out_ready(out_ready), .out_valid(b_valid), .random_out(b_out), .busy(b_busy)
    );

    function automatic logic [42:0] ref_lfsr(input logic [42:0] s);
        logic [42:0] n;
        if (s == 43'd0) return L_INIT;
        for (int i = 0; i < 43; i++)
            n[i] = (i == 0) ? s[42] : (s[i-1] ^ (L_TAPS[i] & s[42]));
        return n;
    endfunction

    function automatic logic [36:0] ref_casr(input logic [36:0] s);
        logic [36:0] n;
        if (s == 37'd0) return C_INIT;
        for (int i = 0; i < 37; i++)
            n[i] = s[(i + 36) % 37] ^ s[(i + 1) % 37] ^ (C_MASK[i] & s[i]);
        return n;
    endfunction

    function automatic logic [31:0] ref_pick(input logic [1:0] md, input logic [42:0] l,
                                             input logic [36:0] c);
        if (md == 2'd1) return l[31:0];
        if (md == 2'd2) return c[31:0];
        return l[31:0] ^ c[31:0];
    endfunction

    // Model one rising edge: samples appear once WARMUP steps have elapsed.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_l[k] = L_INIT; m_c[k] = C_INIT; m_n[k] = 0; m_v[k] = 1'b0; m_o[k] = 32'd0;
            end else if (load) begin
                m_l[k] = {11'd0, seed}; m_c[k] = {5'd0, seed}; m_n[k] = 0; m_v[k] = 1'b0;
            end else begin
                if (m_n[k] >= wu[k] && (!m_v[k] || out_ready)) begin
                    m_o[k] = ref_pick(mode, m_l[k], m_c[k]);
                    m_v[k] = 1'b1;
                end
                m_l[k] = ref_lfsr(m_l[k]);
                m_c[k] = ref_casr(m_c[k]);
                if (m_n[k] < wu[k]) m_n[k] = m_n[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("a_valid", {63'd0, a_valid}, {63'd0, m_v[0]});
        chk("a_out",   {32'd0, a_out},   {32'd0, m_o[0]});
        chk("a_busy",  {63'd0, a_busy},  {63'd0, (m_n[0] < wu[0])});
        chk("b_valid", {63'd0, b_valid}, {63'd0, m_v[1]});
        chk("b_out",   {32'd0, b_out},   {32'd0, m_o[1]});
        chk("b_busy",  {63'd0, b_busy},  {63'd0, (m_n[1] < wu[1])});
    endtask

    initial begin
        logic [31:0] held;
        reset = 1'b1; load = 1'b0; seed = 32'd0; mode = 2'd0; out_ready = 1'b1;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_out", {32'd0, a_out}, 64'd0);
        chk("rst_busy", {63'd0, a_busy}, 64'd1);

        // Warm-up latency with WARMUP=4, then one sample per edge.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("wu_novalid", {63'd0, a_valid}, 64'd0);
        end
        cyc();
        chk("wu_first", {63'd0, a_valid}, 64'd1);
        for (int i = 0; i < 6; i++) cyc();

        // Seed 1, LFSR only, WARMUP=1: sample is one step of seed.
        load = 1'b1; seed = 32'h1; mode = 2'd1; cyc();
        load = 1'b0; cyc(); cyc();
        chk("seed1_out", {32'd0, b_out}, 64'h2);
        chk("seed1_val", {63'd0, b_valid}, 64'd1);

        // Zero seed recovers to init values; XOR mode.
        load = 1'b1; seed = 32'h0; mode = 2'd0; cyc();
        load = 1'b0; cyc(); cyc();
        chk("zero_out", {32'd0, b_out}, 64'hA9ED8C5F);

        // Backpressure: held sample survives ten stalled cycles and mode changes.
        for (int i = 0; i < 6; i++) cyc();
        out_ready = 1'b0;
        cyc();
        held = a_out;
        for (int i = 0; i < 10; i++) begin
            mode = 2'($urandom_range(0, 3));
            cyc();
            chk("hold_out", {32'd0, a_out}, {32'd0, held});
        end
        out_ready = 1'b1; cyc(); cyc();

        // Load in RUN with out_ready high; capture in mode 11.
        load = 1'b1; seed = $urandom; mode = 2'd3; cyc();
        load = 1'b0;
        for (int i = 0; i < 8; i++) cyc();

        // Reset mid-run together with load.
        reset = 1'b1; load = 1'b1; cyc();
        chk("rst_load_out", {32'd0, a_out}, 64'd0);
        chk("rst_load_busy", {63'd0, b_busy}, 64'd1);
        reset = 1'b0; load = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 79) == 0);
            load      = ($urandom_range(0, 29) == 0);
            seed      = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            mode      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
